// File: rtl/tictactoe4x4_judge.sv
// Registered judge for a 4x4 tic-tac-toe position.
// Each clock the two occupancy maps are classified as A win, B win, draw or
// illegal. The result is registered, so it appears one cycle after the edge
// that sampled the maps.
`timescale 1ns/1ps

module tictactoe4x4_judge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_cells,
  input  logic [15:0] b_cells,
  output logic        a_win,
  output logic        b_win,
  output logic        draw,
  output logic        error,
  output logic [3:0]  win_line
);

  localparam int unsigned CELLS     = 16;
  localparam int unsigned NUM_LINES = 10;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned IDX_W     = 4;

  localparam logic [IDX_W-1:0] NO_LINE    = IDX_W'(15);
  localparam logic [CELLS-1:0] FULL_BOARD = 16'hFFFF;

  // Cell masks of the ten lines, indexed by their reported line number.
  // Bit k-1 is cell k, row-major.
  localparam logic [CELLS-1:0] LINE_MASK [NUM_LINES] = '{
    16'h000F,  // 0: row 0
    16'h00F0,  // 1: row 1
    16'h0F00,  // 2: row 2
    16'hF000,  // 3: row 3
    16'h1111,  // 4: column 0
    16'h2222,  // 5: column 1
    16'h4444,  // 6: column 2
    16'h8888,  // 7: column 3
    16'h8421,  // 8: main diagonal, cells 1-6-11-16
    16'h1248   // 9: anti-diagonal, cells 4-7-10-13
  };

  logic [NUM_LINES-1:0] a_own_c;
  logic [NUM_LINES-1:0] b_own_c;
  logic [CNT_W-1:0]     cnt_a_c;
  logic [CNT_W-1:0]     cnt_b_c;
  logic [CNT_W-1:0]     cnt_diff_c;
  logic                 overlap_c;
  logic                 count_bad_c;
  logic                 both_win_c;
  logic                 full_c;
  logic                 a_any_c;
  logic                 b_any_c;
  logic [IDX_W-1:0]     a_idx_c;
  logic [IDX_W-1:0]     b_idx_c;

  logic                 a_win_c;
  logic                 b_win_c;
  logic                 draw_c;
  logic                 error_c;
  logic [IDX_W-1:0]     win_line_c;

  // Line ownership: a player owns a line when every cell of its mask is set.
  always_comb begin
    a_own_c = '0;
    b_own_c = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      a_own_c[i] = ((a_cells & LINE_MASK[i]) == LINE_MASK[i]);
      b_own_c[i] = ((b_cells & LINE_MASK[i]) == LINE_MASK[i]);
    end
  end

  // Piece counts of both players.
  always_comb begin
    cnt_a_c = '0;
    cnt_b_c = '0;
    for (int i = 0; i < CELLS; i++) begin
      cnt_a_c = cnt_a_c + CNT_W'(a_cells[i]);
      cnt_b_c = cnt_b_c + CNT_W'(b_cells[i]);
    end
  end

  // Absolute count difference; unsigned subtraction ordered to avoid wrap.
  always_comb begin
    if (cnt_a_c >= cnt_b_c) begin
      cnt_diff_c = cnt_a_c - cnt_b_c;
    end else begin
      cnt_diff_c = cnt_b_c - cnt_a_c;
    end
  end

  // Lowest owned line per player; scanning downward leaves the smallest index.
  always_comb begin
    a_idx_c = NO_LINE;
    b_idx_c = NO_LINE;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (a_own_c[i]) begin
        a_idx_c = IDX_W'(i);
      end
      if (b_own_c[i]) begin
        b_idx_c = IDX_W'(i);
      end
    end
  end

  // Legality checks and final classification; error overrides everything.
  always_comb begin
    a_any_c     = |a_own_c;
    b_any_c     = |b_own_c;
    overlap_c   = |(a_cells & b_cells);
    count_bad_c = (cnt_diff_c > CNT_W'(1));
    both_win_c  = a_any_c && b_any_c;
    full_c      = ((a_cells | b_cells) == FULL_BOARD);
    error_c     = overlap_c || count_bad_c || both_win_c;

    a_win_c    = 1'b0;
    b_win_c    = 1'b0;
    draw_c     = 1'b0;
    win_line_c = NO_LINE;

    if (!error_c) begin
      if (a_any_c) begin
        a_win_c    = 1'b1;
        win_line_c = a_idx_c;
      end else if (b_any_c) begin
        b_win_c    = 1'b1;
        win_line_c = b_idx_c;
      end else if (full_c) begin
        draw_c     = 1'b1;
      end
    end
  end

  // Output registers; reset clears all flags and reports no line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_win    <= 1'b0;
      b_win    <= 1'b0;
      draw     <= 1'b0;
      error    <= 1'b0;
      win_line <= NO_LINE;
    end else begin
      a_win    <= a_win_c;
      b_win    <= b_win_c;
      draw     <= draw_c;
      error    <= error_c;
      win_line <= win_line_c;
    end
  end

endmodule

// File: tb/tb_tictactoe4x4_judge.sv
// Scoreboard bench for tictactoe4x4_judge: stimulus pushes expected results,
// a monitor pops and compares them one cycle after each sampling edge.
`timescale 1ns/1ps

module tb_tictactoe4x4_judge;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_cells;
  logic [15:0] b_cells;
  logic        a_win;
  logic        b_win;
  logic        draw;
  logic        error;
  logic [3:0]  win_line;

  // Expected result vector layout: {a_win, b_win, draw, error, win_line}.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  res;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  tictactoe4x4_judge dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_cells  (a_cells),
    .b_cells  (b_cells),
    .a_win    (a_win),
    .b_win    (b_win),
    .draw     (draw),
    .error    (error),
    .win_line (win_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dut_vec();
    return {a_win, b_win, draw, error, win_line};
  endfunction

  task automatic check(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s a=%h b=%h got{aw,bw,dr,er,line}=%b_%0d want=%b_%0d",
               name, a, b, got[7:4], got[3:0], want[7:4], want[3:0]);
    end
  endtask

  // Reference model: builds a 4x4 grid and walks the rows, columns and
  // diagonals by coordinates.
  function automatic logic [7:0] model(input logic [15:0] a, input logic [15:0] b);
    bit ga[4][4];
    bit gb[4][4];
    int na, nb, diff;
    int first_a, first_b;
    bit overlap, full, err;
    bit aw, bw, dr;
    int line;
    na = 0; nb = 0; overlap = 0; full = 1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ga[r][c] = a[r*4+c];
        gb[r][c] = b[r*4+c];
        na += int'(ga[r][c]);
        nb += int'(gb[r][c]);
        if (ga[r][c] && gb[r][c]) overlap = 1;
        if (!ga[r][c] && !gb[r][c]) full = 0;
      end
    end
    first_a = -1; first_b = -1;
    for (int l = 0; l < 10; l++) begin
      bit all_a, all_b;
      all_a = 1; all_b = 1;
      for (int j = 0; j < 4; j++) begin
        int r, c;
        if (l < 4)       begin r = l; c = j;     end
        else if (l < 8)  begin r = j; c = l - 4; end
        else if (l == 8) begin r = j; c = j;     end
        else             begin r = j; c = 3 - j; end
        if (!ga[r][c]) all_a = 0;
        if (!gb[r][c]) all_b = 0;
      end
      if (all_a && first_a < 0) first_a = l;
      if (all_b && first_b < 0) first_b = l;
    end
    diff = (na > nb) ? na - nb : nb - na;
    err  = overlap || (diff > 1) || (first_a >= 0 && first_b >= 0);
    aw = 0; bw = 0; dr = 0; line = 15;
    if (!err) begin
      if (first_a >= 0)      begin aw = 1; line = first_a; end
      else if (first_b >= 0) begin bw = 1; line = first_b; end
      else if (full)         dr = 1;
    end
    return {aw, bw, dr, err, 4'(line)};
  endfunction

  task automatic drive_exp(input logic [15:0] a, input logic [15:0] b, input logic [7:0] want);
    exp_t e;
    @(negedge clk);
    a_cells = a;
    b_cells = b;
    e.a = a; e.b = b; e.res = want;
    exp_q.push_back(e);
  endtask

  task automatic drive_model(input logic [15:0] a, input logic [15:0] b);
    drive_exp(a, b, model(a, b));
  endtask

  // Random legal-ish game: alternating moves onto empty cells.
  task automatic random_game(output logic [15:0] a, output logic [15:0] b);
    int n, k;
    bit turn_a;
    logic [15:0] occ;
    a = '0; b = '0;
    n = $urandom_range(0, 16);
    turn_a = 1'($urandom_range(0, 1));
    for (int m = 0; m < n; m++) begin
      occ = a | b;
      k = $urandom_range(0, 15);
      while (occ[k]) k = (k + 1) % 16;
      if (turn_a) a[k] = 1'b1; else b[k] = 1'b1;
      turn_a = !turn_a;
    end
  endtask

  // Monitor: one expected entry is due per sampling edge while any are queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", e.a, e.b, dut_vec(), e.res);
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    int wait_cycles;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    a_cells = 16'h000F;
    b_cells = 16'h0270;
    #12;
    check("reset_state", a_cells, b_cells, dut_vec(), 8'h0F);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived results.
    drive_exp(16'h000F, 16'h0270, 8'h80);  // A row 0
    drive_exp(16'h0650, 16'h000F, 8'h40);  // B row 0
    drive_exp(16'h0013, 16'hBC00, 8'h1F);  // count difference 2
    drive_exp(16'h0001, 16'h0001, 8'h1F);  // overlap
    drive_exp(16'hC3C3, 16'h3C3C, 8'h2F);  // full board draw
    drive_exp(16'hC3C2, 16'h3C3C, 8'h0F);  // one cell cleared
    drive_exp(16'h0000, 16'h0000, 8'h0F);  // empty board
    drive_exp(16'h111F, 16'hCA60, 8'h80);  // row 0 and col 0: lowest index
    drive_exp(16'h8421, 16'h0112, 8'h88);  // main diagonal
    drive_exp(16'h1248, 16'h0111, 8'h89);  // anti-diagonal
    drive_exp(16'h0111, 16'h8888, 8'h47);  // B column 3
    drive_exp(16'h000F, 16'hF000, 8'h1F);  // both players own a line

    // Mid-cycle reset clears outputs at once; first edge after release re-evaluates.
    drive_exp(16'h000F, 16'h0270, 8'h80);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", a_cells, b_cells, dut_vec(), 8'h0F);
    @(posedge clk);
    #1;
    check("reset_hold", a_cells, b_cells, dut_vec(), 8'h0F);
    drive_exp(16'h000F, 16'h0270, 8'h80);
    rst_n = 1'b1;

    // Randomized positions against the reference model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = 16'($urandom); rb = 16'($urandom); end
        1: begin ra = 16'($urandom); rb = ~ra & 16'($urandom); end
        default: random_game(ra, rb);
      endcase
      drive_model(ra, rb);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 100) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
